ser_word_framer: RTL and testbench
==================================

# ser_word_framer

Transmit-side counterpart of the sensor deserializer and word aligner: accepts pixel words on a valid/ready stream and emits one serial bit per `clk` as a continuous word stream. It sends training words while idle, wraps each line in 4-word sync sequences (SOF/SOL before, EOL/EOF after), and shifts bits out in `SER_FIRST_BIT` order. It sits in front of the LVDS output buffer, and serves as the sensor stimulus for the deserializer bench.

## Interface
- `SER_FIRST_BIT`, "MSB": first serialized bit of each word, "MSB" or "LSB".
- `DESER_WIDTH`, 10: word width in bits; legal values are 8, 10 and 12.
- `TRAINING_WORD`, 10'h3A6: idle/filler word, `DESER_WIDTH` bits.
- `clk` in 1: bit clock. Single clock domain.
- `reset` in 1: synchronous, active-low reset.
- `iv_pix_data` in `DESER_WIDTH`: pixel word.
- `i_valid` in 1: `iv_pix_data`, `i_sof` and `i_eol` are valid.
- `i_sof` in 1: this pixel is the first pixel of a frame.
- `i_eol` in 1: this pixel is the last pixel of a line.
- `i_eof` in 1: qualifies `i_eol`; the line is the last line of the frame.
- `o_ready` in/out: out 1. Pixel is consumed this clock when `i_valid` is also high.
- `o_ser_data` out 1: serial bit.
- `o_word_start` out 1: high on the first bit of every word.

## Operation
- **Word slot.** Each word occupies `DESER_WIDTH` clocks.
  - A bit counter `cnt` runs 0..W-1.
  - The clock where `cnt`=W-1 is the *load clock*. On it, the next word is chosen and loaded into the shift register.
- **Sync sequence.** Four words: PRE0, PRE1, PRE2, CODE.
  - Constants are 12-bit, left-justified; the upper W bits are used.
  - PRE0=12'hFFF, PRE1=12'h000, PRE2=12'h000.
  - SOF=12'hAB0, SOL=12'h800, EOL=12'h9D0, EOF=12'hB60.
  - For W=10 these give 3FF, 000, 000 and 2AC/200/274/2D8.
- **States:** `S_IDLE`, `S_SOL_SYNC`, `S_DATA`, `S_EOL_SYNC`. A 2-bit sync index counts 0..3 within the sync states.
  - **`S_IDLE`:** emits `TRAINING_WORD`. If `i_valid` is high on the load clock, the pixel and flags are latched into a hold register. The FSM then goes to `S_SOL_SYNC`, with code SOF if `i_sof`, else SOL.
  - **`S_SOL_SYNC`:** emits the 4 sync words, then goes to `S_DATA`. The first `S_DATA` slot emits the held pixel; no input is consumed in that slot.
  - **`S_DATA`:**
    - Each later load clock with `i_valid` consumes and emits the pixel.
    - A load clock without `i_valid` emits `TRAINING_WORD` as a gap and stays in `S_DATA`.
    - After the pixel with `i_eol` is emitted, the FSM goes to `S_EOL_SYNC`, with code EOF if `i_eof`, else EOL.
    - `i_sof` is ignored in `S_DATA`.
  - **`S_EOL_SYNC`:** emits the 4 sync words, then goes to `S_IDLE`.
- **`o_ready` rule.** `o_ready` is combinational and high only on a load clock when:
  - the state is `S_IDLE`, or
  - the state is `S_DATA` and the current slot is not the held-pixel slot.

  Outside those clocks it is 0. The source must hold its data until it sees `o_ready`.
- **Corner cases.**
  - A pixel carrying both `i_sof` and `i_eol` gives a one-pixel line: SOF sync, pixel, EOL/EOF sync.
  - `i_eof` without `i_eol` has no effect.
- **Reset mid-word.** The partial word is abandoned and the FSM returns to `S_IDLE`. Any held pixel is dropped.

## Timing
- **Reset values:**
  - `o_ser_data`=0, `o_word_start`=0, `o_ready`=0 while `reset`=0.
  - Internally `cnt`=W-1 and the shift register is 0.
- **After reset.** The first clock with `reset`=1 is a load clock. The first bit of the first `TRAINING_WORD` appears on the next clock, with `o_word_start`=1.
- **`S_DATA` latency.** A pixel consumed in `S_DATA` at load clock T has its first bit on `o_ser_data` at T+1 and its last bit at T+W.
- **`S_IDLE` latency.** A pixel consumed in `S_IDLE` at load clock T has its first bit at T+1+4W.
- **Bit order.** With "MSB", bit W-1 goes first; with "LSB", bit 0 goes first.
- **Continuity.** Output is continuous, with no idle clocks between words.

## Configuration
- **`SER_TEST_PATTERN_EN` defined:**
  - Adds port `i_test_mode` (in, 1 bit).
  - While it is high, every consumed pixel word is replaced by a W-bit ramp.
  - The ramp is 0 on the first pixel after each SOF/SOL sync, increments per emitted pixel, and wraps at 2^W-1 → 0.
  - Handshake and flags are unchanged.
- **Not defined:** the port is absent and pixel data passes unmodified.

## Structure
- Package `ser_word_pkg` holds:
  - the 12-bit sync constants (PRE0..2, SOF, SOL, EOL, EOF);
  - the FSM state encoding;
  - a function selecting the upper W bits.
- Sub-module `ser_shift_out` contains the bit counter, the shift register, the `SER_FIRST_BIT` ordering and `o_word_start`. It exposes a load strobe and a parallel-load input.
- `ser_word_framer` itself holds the FSM, the hold register, the `o_ready` logic and the ramp.

## Test plan
All scenarios use W=10, MSB first unless stated otherwise.
- **Reset/idle:** release `reset` with `i_valid`=0 → `o_word_start` every 10 clocks, each word 3A6, bits 1,1,1,0,1,0,0,1,1,0.
- **Single line:** i_valid with i_sof and data 155, 0AA, 3C3, where i_eol is on 3C3 → words 3FF, 000, 000, 2AC, 155, 0AA, 3C3, 3FF, 000, 000, 274, then 3A6.
- **Gap in line:** drop `i_valid` for one slot mid-line → one 3A6 word appears between the pixels, and state remains `S_DATA`.
- **End of frame:** last pixel carries `i_eol`+`i_eof` → the trailing code is 2D8; the next line without `i_sof` starts with code 200.
- **LSB first:** with `SER_FIRST_BIT`="LSB", word 001 serializes as 1 followed by nine 0s.
- **Reset mid-line and ramp:**
  - Assert `reset` during a pixel word → outputs are 0 the next clock, and after release the stream resumes with 3A6.
  - With `SER_TEST_PATTERN_EN` and `i_test_mode`=1, a 3-pixel line emits 000, 001, 002.

Source files
------------

// File: rtl/ser_word_pkg.sv
// ----------------------------------------------------------------------------
// ser_word_pkg
// Shared definitions for the serial word framer:
//   - 12-bit left-justified sync constants (preambles and line/frame codes)
//   - framer FSM state encoding
//   - sync_upper(): extracts the upper `width` bits of a 12-bit sync constant,
//     returned right-justified in a 12-bit value
// ----------------------------------------------------------------------------
package ser_word_pkg;

    localparam logic [11:0] SYNC_PRE0 = 12'hFFF;
    localparam logic [11:0] SYNC_PRE1 = 12'h000;
    localparam logic [11:0] SYNC_PRE2 = 12'h000;
    localparam logic [11:0] SYNC_SOF  = 12'hAB0;
    localparam logic [11:0] SYNC_SOL  = 12'h800;
    localparam logic [11:0] SYNC_EOL  = 12'h9D0;
    localparam logic [11:0] SYNC_EOF  = 12'hB60;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SOL_SYNC = 2'd1,
        S_DATA     = 2'd2,
        S_EOL_SYNC = 2'd3
    } state_e;

    // The constants are left-justified, so narrower words keep the top bits.
    function automatic logic [11:0] sync_upper(input logic [11:0] code, input int width);
        sync_upper = code >> (12 - width);
    endfunction

endpackage

// File: rtl/ser_shift_out.sv
// ----------------------------------------------------------------------------
// ser_shift_out
// Bit-slot engine of the framer: a bit counter running 0..W-1, a parallel-load
// shift register and the first-bit ordering. The clock where the counter sits
// at W-1 is the load clock; load_word_i is captured there and its first bit
// appears on ser_data_o on the following clock together with word_start_o.
//
// Ports:
//   clk          in   bit clock
//   reset        in   synchronous active-low reset
//   load_word_i  in   W-bit word captured on the load clock
//   load_o       out  high on the load clock (last bit of the current word)
//   ser_data_o   out  serial bit (straight from the shift register)
//   word_start_o out  high on the first bit of every word (registered)
// ----------------------------------------------------------------------------
module ser_shift_out #(
    parameter int    DESER_WIDTH   = 10,
    parameter string SER_FIRST_BIT = "MSB"
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DESER_WIDTH-1:0] load_word_i,
    output logic                   load_o,
    output logic                   ser_data_o,
    output logic                   word_start_o
);

    localparam int               CNT_W     = $clog2(DESER_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DESER_WIDTH - 1);
    localparam bit               LSB_FIRST = (SER_FIRST_BIT == "LSB");

    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DESER_WIDTH-1:0] shreg_q, shreg_d;
    logic [DESER_WIDTH-1:0] ordered_s;
    logic                   word_start_q, word_start_d;

    assign load_o       = (cnt_q == CNT_LAST);
    assign ser_data_o   = shreg_q[DESER_WIDTH-1];
    assign word_start_o = word_start_q;

    // Reorder the word so the bit to transmit first always sits at the MSB.
    always_comb begin
        ordered_s = load_word_i;
        if (LSB_FIRST) begin
            for (int i = 0; i < DESER_WIDTH; i++) begin
                ordered_s[i] = load_word_i[DESER_WIDTH-1-i];
            end
        end else begin
            ordered_s = load_word_i;
        end
    end

    // Counter, shifter and word-start next state.
    always_comb begin
        cnt_d        = cnt_q + CNT_W'(1);
        shreg_d      = {shreg_q[DESER_WIDTH-2:0], 1'b0};
        word_start_d = 1'b0;
        if (load_o) begin
            cnt_d        = {CNT_W{1'b0}};
            shreg_d      = ordered_s;
            word_start_d = 1'b1;
        end else begin
            word_start_d = 1'b0;
        end
    end

    // State registers; reset parks the counter on the load position.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q        <= CNT_LAST;
            shreg_q      <= {DESER_WIDTH{1'b0}};
            word_start_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            word_start_q <= word_start_d;
        end
    end

endmodule

// File: rtl/ser_word_framer.sv
// ----------------------------------------------------------------------------
// ser_word_framer
// Serializes a valid/ready pixel stream into a continuous word stream: training
// words while idle, each line wrapped in PRE0/PRE1/PRE2/CODE sync sequences
// (SOF or SOL before, EOL or EOF after), one bit per clock.
//
// Optional feature macro: SER_TEST_PATTERN_EN
//   When defined, adds i_test_mode; while high, emitted pixels are replaced by
//   a W-bit ramp that restarts at 0 on the first pixel of every line.
//
// Ports:
//   clk          in   bit clock
//   reset        in   synchronous active-low reset
//   iv_pix_data  in   pixel word (DESER_WIDTH bits)
//   i_valid      in   pixel and flags valid
//   i_sof        in   first pixel of a frame
//   i_eol        in   last pixel of a line
//   i_eof        in   with i_eol: last line of the frame
//   i_test_mode  in   ramp substitution (SER_TEST_PATTERN_EN only)
//   o_ready      out  pixel consumed this clock if i_valid (combinational)
//   o_ser_data   out  serial bit
//   o_word_start out  first bit of every word
// ----------------------------------------------------------------------------
module ser_word_framer
    import ser_word_pkg::*;
#(
    parameter string                  SER_FIRST_BIT = "MSB",
    parameter int                     DESER_WIDTH   = 10,
    parameter logic [DESER_WIDTH-1:0] TRAINING_WORD = DESER_WIDTH'(10'h3A6)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DESER_WIDTH-1:0] iv_pix_data,
    input  logic                   i_valid,
    input  logic                   i_sof,
    input  logic                   i_eol,
    input  logic                   i_eof,
`ifdef SER_TEST_PATTERN_EN
    input  logic                   i_test_mode,
`endif
    output logic                   o_ready,
    output logic                   o_ser_data,
    output logic                   o_word_start
);

    state_e                 state_q, state_d;
    logic [1:0]             idx_q, idx_d;
    logic [DESER_WIDTH-1:0] code_q, code_d;
    logic [DESER_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                   hold_eol_q, hold_eol_d;
    logic                   hold_eof_q, hold_eof_d;
    logic                   held_slot_q, held_slot_d;

    logic                   load_s;
    logic                   ready_s;
    logic [DESER_WIDTH-1:0] word_s;
    logic [DESER_WIDTH-1:0] sync_word_s;
    logic [DESER_WIDTH-1:0] pix_live_s;
    logic [DESER_WIDTH-1:0] pix_held_s;

`ifdef SER_TEST_PATTERN_EN
    logic [DESER_WIDTH-1:0] ramp_q, ramp_d;

    // Ramp replaces the pixel value at the moment the pixel is emitted.
    always_comb begin
        if (i_test_mode) begin
            pix_live_s = ramp_q;
            pix_held_s = ramp_q;
        end else begin
            pix_live_s = iv_pix_data;
            pix_held_s = hold_data_q;
        end
    end
`else
    assign pix_live_s = iv_pix_data;
    assign pix_held_s = hold_data_q;
`endif

    ser_shift_out #(
        .DESER_WIDTH   (DESER_WIDTH),
        .SER_FIRST_BIT (SER_FIRST_BIT)
    ) u_shift (
        .clk          (clk),
        .reset        (reset),
        .load_word_i  (word_s),
        .load_o       (load_s),
        .ser_data_o   (o_ser_data),
        .word_start_o (o_word_start)
    );

    // Gate with reset so the handshake stays low while reset is held.
    assign o_ready = reset & ready_s;

    // Sync word indexed by position within the 4-word sequence.
    always_comb begin
        case (idx_q)
            2'd0:    sync_word_s = DESER_WIDTH'(sync_upper(SYNC_PRE0, DESER_WIDTH));
            2'd1:    sync_word_s = DESER_WIDTH'(sync_upper(SYNC_PRE1, DESER_WIDTH));
            2'd2:    sync_word_s = DESER_WIDTH'(sync_upper(SYNC_PRE2, DESER_WIDTH));
            default: sync_word_s = code_q;
        endcase
    end

    // FSM next state, word selection and handshake; all decisions are taken on
    // the load clock and choose the word for the following slot. The state
    // therefore already names the sequence the next loaded word belongs to.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        code_d      = code_q;
        hold_data_d = hold_data_q;
        hold_eol_d  = hold_eol_q;
        hold_eof_d  = hold_eof_q;
        held_slot_d = held_slot_q;
        ready_s     = 1'b0;
        word_s      = TRAINING_WORD;
`ifdef SER_TEST_PATTERN_EN
        ramp_d      = ramp_q;
`endif
        if (load_s) begin
            case (state_q)
                S_IDLE: begin
                    ready_s = 1'b1;
                    if (i_valid) begin
                        // PRE0 goes out immediately; the pixel waits four slots.
                        word_s      = DESER_WIDTH'(sync_upper(SYNC_PRE0, DESER_WIDTH));
                        hold_data_d = iv_pix_data;
                        hold_eol_d  = i_eol;
                        hold_eof_d  = i_eof;
                        if (i_sof) begin
                            code_d = DESER_WIDTH'(sync_upper(SYNC_SOF, DESER_WIDTH));
                        end else begin
                            code_d = DESER_WIDTH'(sync_upper(SYNC_SOL, DESER_WIDTH));
                        end
                        idx_d   = 2'd1;
                        state_d = S_SOL_SYNC;
`ifdef SER_TEST_PATTERN_EN
                        ramp_d  = {DESER_WIDTH{1'b0}};
`endif
                    end else begin
                        word_s = TRAINING_WORD;
                    end
                end
                S_SOL_SYNC: begin
                    word_s = sync_word_s;
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d     = S_DATA;
                        held_slot_d = 1'b1;
                    end else begin
                        state_d = S_SOL_SYNC;
                    end
                end
                S_DATA: begin
                    if (held_slot_q) begin
                        // Held-pixel slot: emit the captured pixel, consume nothing.
                        word_s      = pix_held_s;
                        held_slot_d = 1'b0;
`ifdef SER_TEST_PATTERN_EN
                        ramp_d      = ramp_q + DESER_WIDTH'(1);
`endif
                        if (hold_eol_q) begin
                            state_d = S_EOL_SYNC;
                            idx_d   = 2'd0;
                            if (hold_eof_q) begin
                                code_d = DESER_WIDTH'(sync_upper(SYNC_EOF, DESER_WIDTH));
                            end else begin
                                code_d = DESER_WIDTH'(sync_upper(SYNC_EOL, DESER_WIDTH));
                            end
                        end else begin
                            state_d = S_DATA;
                        end
                    end else begin
                        ready_s = 1'b1;
                        if (i_valid) begin
                            word_s = pix_live_s;
`ifdef SER_TEST_PATTERN_EN
                            ramp_d = ramp_q + DESER_WIDTH'(1);
`endif
                            if (i_eol) begin
                                state_d = S_EOL_SYNC;
                                idx_d   = 2'd0;
                                if (i_eof) begin
                                    code_d = DESER_WIDTH'(sync_upper(SYNC_EOF, DESER_WIDTH));
                                end else begin
                                    code_d = DESER_WIDTH'(sync_upper(SYNC_EOL, DESER_WIDTH));
                                end
                            end else begin
                                state_d = S_DATA;
                            end
                        end else begin
                            // Gap slot inside a line.
                            word_s = TRAINING_WORD;
                        end
                    end
                end
                S_EOL_SYNC: begin
                    word_s = sync_word_s;
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_EOL_SYNC;
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    idx_d       = 2'd0;
                    held_slot_d = 1'b0;
                end
            endcase
        end else begin
            word_s = TRAINING_WORD;
        end
    end

    // FSM and hold registers; reset drops any held pixel.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            idx_q       <= 2'd0;
            code_q      <= {DESER_WIDTH{1'b0}};
            hold_data_q <= {DESER_WIDTH{1'b0}};
            hold_eol_q  <= 1'b0;
            hold_eof_q  <= 1'b0;
            held_slot_q <= 1'b0;
`ifdef SER_TEST_PATTERN_EN
            ramp_q      <= {DESER_WIDTH{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            code_q      <= code_d;
            hold_data_q <= hold_data_d;
            hold_eol_q  <= hold_eol_d;
            hold_eof_q  <= hold_eof_d;
            held_slot_q <= held_slot_d;
`ifdef SER_TEST_PATTERN_EN
            ramp_q      <= ramp_d;
`endif
        end
    end

endmodule

// File: tb/tb_ser_word_framer.sv
module tb_ser_word_framer;

    localparam int           W     = 10;
    localparam logic [W-1:0] TRAIN = 10'h3A6;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] pix = '0;
    logic         valid = 1'b0;
    logic         sof = 1'b0;
    logic         eol = 1'b0;
    logic         eof = 1'b0;
    logic         test_mode = 1'b0;
    logic         ready_m, ser_m, ws_m;
    logic         ready_l, ser_l, ws_l;

    int checks = 0;
    int errors = 0;

    // reference model state: words committed to upcoming slots
    logic [W-1:0] sched[$];
    logic         in_line = 1'b0;
    logic [W-1:0] ramp_m = '0;
    logic [W-1:0] cur_exp = '0;
    logic         cur_valid = 1'b0;
    logic [W-1:0] acc_m = '0;
    logic [W-1:0] acc_l = '0;
    logic [W-1:0] obs_q[$];
    logic [W-1:0] line_ref[12];

    always #5 clk = ~clk;

    ser_word_framer #(.SER_FIRST_BIT("MSB"), .DESER_WIDTH(W), .TRAINING_WORD(TRAIN)) dut (
        .clk(clk), .reset(reset), .iv_pix_data(pix), .i_valid(valid),
        .i_sof(sof), .i_eol(eol), .i_eof(eof),
`ifdef SER_TEST_PATTERN_EN
        .i_test_mode(test_mode),
`endif
        .o_ready(ready_m), .o_ser_data(ser_m), .o_word_start(ws_m));

    ser_word_framer #(.SER_FIRST_BIT("LSB"), .DESER_WIDTH(W), .TRAINING_WORD(TRAIN)) dut_lsb (
        .clk(clk), .reset(reset), .iv_pix_data(pix), .i_valid(valid),
        .i_sof(sof), .i_eol(eol), .i_eof(eof),
`ifdef SER_TEST_PATTERN_EN
        .i_test_mode(test_mode),
`endif
        .o_ready(ready_l), .o_ser_data(ser_l), .o_word_start(ws_l));

    initial begin
        #800000;
        $display("FAIL timeout observed=no finish expected=finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] up(input logic [11:0] c);
        logic [11:0] t;
        t = c;
        return t[11 -: W];
    endfunction

    task automatic push_sync(input logic [11:0] code);
        sched.push_back(up(12'hFFF));
        sched.push_back(up(12'h000));
        sched.push_back(up(12'h000));
        sched.push_back(up(code));
    endtask

    task automatic model_reset();
        sched.delete();
        in_line = 1'b0;
        cur_valid = 1'b0;
    endtask

    // one load clock of the word-queue model
    task automatic model_load(input logic v, input logic [W-1:0] d, input logic s, input logic e,
                              input logic f, input logic tm, output logic er,
                              output logic [W-1:0] nw, output logic took);
        logic [W-1:0] px;
        took = 1'b0;
        if (sched.size() > 0) begin
            er = 1'b0;
            nw = sched.pop_front();
        end else begin
            er = 1'b1;
            if (!v) begin
                nw = TRAIN;
            end else begin
                took = 1'b1;
                if (!in_line) ramp_m = '0;
                px = tm ? ramp_m : d;
                ramp_m = ramp_m + 1'b1;
                if (!in_line) begin
                    in_line = 1'b1;
                    nw = up(12'hFFF);
                    sched.push_back(up(12'h000));
                    sched.push_back(up(12'h000));
                    sched.push_back(s ? up(12'hAB0) : up(12'h800));
                    sched.push_back(px);
                end else begin
                    nw = px;
                end
                if (e) begin
                    push_sync(f ? 12'hB60 : 12'h9D0);
                    in_line = 1'b0;
                end
            end
        end
    endtask

    // at the negedge of a load clock: last bit of the word in flight
    task automatic finish_word();
        acc_m = {acc_m[W-2:0], ser_m};
        acc_l[W-1] = ser_l;
        check("ws_last_msb", W'(ws_m), W'(1'b0));
        check("ws_last_lsb", W'(ws_l), W'(1'b0));
        if (cur_valid) begin
            check("word_msb", acc_m, cur_exp);
            check("word_lsb", acc_l, cur_exp);
            obs_q.push_back(acc_m);
        end
    endtask

    task automatic drive_load(input logic v, input logic [W-1:0] d, input logic s, input logic e,
                              input logic f, output logic took);
        logic         er;
        logic [W-1:0] nw;
        valid = v; pix = d; sof = s; eol = e; eof = f;
        #1;
        model_load(v, d, s, e, f, test_mode, er, nw, took);
        check("ready_msb", W'(ready_m), W'(er));
        check("ready_lsb", W'(ready_l), W'(er));
        cur_exp = nw;
        cur_valid = 1'b1;
    endtask

    task automatic run_slot();
        @(posedge clk);
        for (int k = 0; k < W - 1; k++) begin
            @(negedge clk);
            acc_m = {acc_m[W-2:0], ser_m};
            acc_l[k] = ser_l;
            if (k == 0) begin
                check("ws_first_msb", W'(ws_m), W'(1'b1));
                check("ws_first_lsb", W'(ws_l), W'(1'b1));
            end else begin
                check("ws_mid_msb", W'(ws_m), W'(1'b0));
                check("ws_mid_lsb", W'(ws_l), W'(1'b0));
            end
            @(posedge clk);
        end
        @(negedge clk);
    endtask

    task automatic step(input logic v, input logic [W-1:0] d, input logic s, input logic e, input logic f);
        logic took;
        finish_word();
        drive_load(v, d, s, e, f, took);
        run_slot();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, W'($urandom), 1'b0, 1'b0, 1'b0);
    endtask

    // hold the pixel until the model sees it consumed
    task automatic send_pixel(input logic [W-1:0] d, input logic s, input logic e, input logic f);
        logic took;
        int   n;
        took = 1'b0;
        n = 0;
        while (!took && n < 20) begin
            finish_word();
            drive_load(1'b1, d, s, e, f, took);
            run_slot();
            n++;
        end
        checks++;
        assert (took) else begin
            errors++;
            $error("FAIL handshake observed=not consumed expected=consumed within 20 slots");
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ser_msb"}, W'(ser_m), W'(1'b0));
        check({tag, "_ws_msb"}, W'(ws_m), W'(1'b0));
        check({tag, "_ready_msb"}, W'(ready_m), W'(1'b0));
        check({tag, "_ser_lsb"}, W'(ser_l), W'(1'b0));
        check({tag, "_ws_lsb"}, W'(ws_l), W'(1'b0));
        check({tag, "_ready_lsb"}, W'(ready_l), W'(1'b0));
    endtask

    // assert reset a few clocks into a pixel word
    task automatic reset_mid(input logic [W-1:0] d);
        logic took;
        finish_word();
        drive_load(1'b1, d, 1'b0, 1'b0, 1'b0, took);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midreset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        valid = 1'b0;
        model_reset();
    endtask

    task automatic check_line_ref();
        int           i;
        logic [W-1:0] o;
        i = 0;
        while (i < obs_q.size() && obs_q[i] == TRAIN) i++;
        for (int j = 0; j < 12; j++) begin
            o = (i + j < obs_q.size()) ? obs_q[i + j] : 'x;
            check("line_ref", o, line_ref[j]);
        end
    endtask

    initial begin
        int   len;
        logic s0;
        logic last;
        line_ref = '{10'h3FF, 10'h000, 10'h000, 10'h2AC, 10'h155, 10'h0AA,
                     10'h3C3, 10'h3FF, 10'h000, 10'h000, 10'h274, 10'h3A6};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        model_reset();

        // idle training words
        idle(4);

        // single line with SOF, literal stream check
        obs_q.delete();
        send_pixel(10'h155, 1'b1, 1'b0, 1'b0);
        send_pixel(10'h0AA, 1'b0, 1'b0, 1'b0);
        send_pixel(10'h3C3, 1'b0, 1'b1, 1'b0);
        idle(8);
        check_line_ref();

        // gap inside a line
        send_pixel(10'h012, 1'b0, 1'b0, 1'b0);
        send_pixel(10'h034, 1'b0, 1'b0, 1'b0);
        step(1'b0, 10'h3FF, 1'b0, 1'b0, 1'b0);
        send_pixel(10'h056, 1'b0, 1'b1, 1'b0);
        idle(6);

        // end of frame; eof without eol and sof inside a line are ignored
        send_pixel(10'h001, 1'b1, 1'b0, 1'b1);
        send_pixel(10'h2F0, 1'b1, 1'b0, 1'b0);
        send_pixel(10'h3FF, 1'b0, 1'b1, 1'b1);
        idle(2);
        send_pixel(10'h077, 1'b0, 1'b1, 1'b0);
        idle(6);

        // one-pixel line with sof and eol together
        send_pixel(10'h200, 1'b1, 1'b1, 1'b1);
        idle(6);

        // reset during a pixel word, then resume with training
        send_pixel(10'h111, 1'b1, 1'b0, 1'b0);
        send_pixel(10'h222, 1'b0, 1'b0, 1'b0);
        reset_mid(10'h333);
        idle(3);
        send_pixel(10'h044, 1'b0, 1'b1, 1'b0);
        idle(6);

`ifdef SER_TEST_PATTERN_EN
        // ramp substitution
        test_mode = 1'b1;
        send_pixel(W'($urandom), 1'b1, 1'b0, 1'b0);
        send_pixel(W'($urandom), 1'b0, 1'b0, 1'b0);
        send_pixel(W'($urandom), 1'b0, 1'b1, 1'b0);
        idle(6);
        test_mode = 1'b0;
        idle(1);
`endif

        // randomized lines
        for (int ln = 0; ln < 25; ln++) begin
            len = $urandom_range(1, 6);
            s0 = 1'($urandom_range(0, 1));
            for (int p = 0; p < len; p++) begin
                if (p > 0 && $urandom_range(0, 3) == 0) step(1'b0, W'($urandom), 1'b0, 1'b0, 1'b0);
                last = (p == len - 1);
                send_pixel(W'($urandom),
                           (p == 0) ? s0 : 1'($urandom_range(0, 4) == 0),
                           last,
                           last ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 4) == 0));
            end
            idle($urandom_range(0, 2));
        end
        idle(7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
